lfsr_delay_gen: RTL
===================

# lfsr_delay_gen

Parametrised pseudo-random delay generator for the reaction-timer datapath. A maximal-length Fibonacci LFSR of selectable width runs when enabled and can be reseeded at run time. On request, the block captures a random value and maps it into a bounded delay. It then counts that delay down on an external tick and pulses `done`, which the game FSM uses to light the stimulus LED.

## Interface
- `WIDTH`, 12: LFSR width. Supported values are 8–16; any other value is a synthesis-time error.
- `RESET_SEED`, 1: LFSR value after reset. Must be nonzero.
- `CNT_W`, 16: delay counter width.
- `MIN_CNT`, 1000: minimum delay, in ticks.
- `SPAN_BITS`, 10: random span is 2^SPAN_BITS ticks. Must satisfy SPAN_BITS ≤ WIDTH and MIN_CNT + 2^SPAN_BITS − 1 < 2^CNT_W.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: advance the LFSR one step this cycle.
- `seed_load` in 1: load `seed` into the LFSR.
- `seed` in WIDTH: reseed value. Zero is replaced by 1.
- `start` in 1: request a random delay.
- `cancel` in 1: abort the delay in progress.
- `tick` in 1: delay time base, a one-cycle strobe.
- `rnd` out WIDTH: current LFSR state (registered).
- `delay_val` out CNT_W: delay captured at the last accepted `start`.
- `busy` out 1: countdown in progress.
- `done` out 1: one-cycle pulse when the delay expires.

## Operation
- **Feedback:** next = {r[WIDTH-2:0], fb}, where fb is the XOR of r at these 1-indexed taps:
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
  - 13: 13,4,3,1
  - 14: 14,5,3,1
  - 15: 15,14
  - 16: 16,15,13,4
- **Period:** 2^WIDTH − 1. The all-zero state is unreachable.
- **LFSR priority per cycle:**
  1. `seed_load`: load `seed`, or 1 if `seed` is 0.
  2. else `en`: step.
  3. else hold.
- **Delay mapping:** D = MIN_CNT + (rnd & (2^SPAN_BITS − 1)), computed in CNT_W bits from the pre-edge `rnd`.
- **States:**
  - IDLE: `busy` = 0.
    - `start` with `cancel` = 0 → capture D into `delay_val` and the counter.
    - If D > 0, go to COUNT.
    - If D = 0, stay in IDLE and pulse `done` next cycle.
  - COUNT: `busy` = 1.
    - `cancel` → IDLE; no `done`; `delay_val` holds.
    - `tick` with counter > 1 → decrement.
    - `tick` with counter = 1 → go to IDLE and pulse `done`.
    - `start` is ignored.
- **Simultaneous events:**
  - `start` with `seed_load` or `en`: D uses the pre-edge `rnd`.
  - `cancel` with `start` in IDLE: `cancel` wins; nothing starts.
  - `cancel` with the final `tick`: `cancel` wins; no `done`.
- **Independence:** `en` is independent of the FSM; the LFSR may keep running during COUNT.

## Timing
- **Reset** (asynchronous, immediate):
  - `rnd` = RESET_SEED, `delay_val` = 0, `busy` = 0, `done` = 0, state IDLE.
  - A reset mid-count discards the delay; no `done` is produced.
- **All outputs registered.** `rnd` updates on the edge where `en` or `seed_load` is sampled.
- **`start` sampled at edge k:** `delay_val` is valid and `busy` = 1 from cycle k+1.
- **Last tick sampled at edge m:** `done` = 1 and `busy` = 0 during cycle m+1; `done` = 0 at m+2.
- **`done` to next `start`:** a `start` sampled during the `done` cycle is accepted.
- **Delay length:** exactly D sampled ticks after acceptance. A `tick` in the same cycle as `start` is not counted.

## Test plan
- **Sequence and period:** WIDTH = 8, RESET_SEED = 1, release reset, hold `en` high. `rnd` must read 0x01, 0x02, 0x04, 0x08, 0x11. It must return to 0x01 after exactly 255 steps, with no repeats and no 0x00 in between.
- **Zero seed and priority:** `seed_load` = 1, `seed` = 0, `en` = 1 in the same cycle. Next `rnd` = 0x01, not a stepped value. Then `seed` = 0xA5 → `rnd` = 0xA5 on the next cycle.
- **Basic delay:** MIN_CNT = 3, SPAN_BITS = 2, `rnd` = 0x06, `start`, then `tick` every cycle. Required:
  - `delay_val` = 5.
  - `busy` high for 5 cycles after `start`.
  - `done` a single cycle, exactly 5 ticks later.
  - `busy` low in the `done` cycle.
- **Cancel:** `cancel` asserted after 2 ticks, and again coincident with the final tick. Both cases: `busy` → 0 next cycle, and no `done` ever.
- **Edge cases:**
  - MIN_CNT = 0 and masked `rnd` = 0 → `done` the cycle after `start`, `busy` stays 0.
  - `start` during COUNT → ignored; `delay_val` unchanged.
- **Reset mid-count:** assert `rst` asynchronously between clock edges. Outputs go to reset values immediately, and no `done` follows.

Source files
------------

// File: rtl/lfsr_delay_gen.sv
// rtl/lfsr_delay_gen.sv - Fibonacci LFSR with bounded random delay countdown
module lfsr_delay_gen #(
  parameter int WIDTH      = 12,
  parameter int RESET_SEED = 1,
  parameter int CNT_W      = 16,
  parameter int MIN_CNT    = 1000,
  parameter int SPAN_BITS  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic             cancel,
  input  logic             tick,
  output logic [WIDTH-1:0] rnd,
  output logic [CNT_W-1:0] delay_val,
  output logic             busy,
  output logic             done
);

  // Tap positions as a bit mask: 1-indexed tap i lives at bit i-1.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      8:       tap_mask = 16'h00B8;  // 8,6,5,4
      9:       tap_mask = 16'h0110;  // 9,5
      10:      tap_mask = 16'h0240;  // 10,7
      11:      tap_mask = 16'h0500;  // 11,9
      12:      tap_mask = 16'h0829;  // 12,6,4,1
      13:      tap_mask = 16'h100D;  // 13,4,3,1
      14:      tap_mask = 16'h2015;  // 14,5,3,1
      15:      tap_mask = 16'h6000;  // 15,14
      16:      tap_mask = 16'hD008;  // 16,15,13,4
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAP16 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS  = TAP16[WIDTH-1:0];

  // Reject parameter sets that would break the feedback polynomial or overflow the counter.
  if (WIDTH < 8 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_delay_gen: WIDTH must be in 8..16");
  end
  if (RESET_SEED == 0) begin : g_bad_seed
    $error("lfsr_delay_gen: RESET_SEED must be nonzero");
  end
  if (SPAN_BITS < 1 || SPAN_BITS > WIDTH) begin : g_bad_span
    $error("lfsr_delay_gen: SPAN_BITS must be in 1..WIDTH");
  end
  if (longint'(MIN_CNT) + (longint'(1) << SPAN_BITS) - 1 >= (longint'(1) << CNT_W)) begin : g_bad_cnt
    $error("lfsr_delay_gen: MIN_CNT + 2^SPAN_BITS - 1 does not fit in CNT_W");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [CNT_W-1:0] delay_val_q, delay_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic                 fb;
  logic [SPAN_BITS-1:0] span;
  logic [CNT_W-1:0]     delay_calc;

  assign fb         = ^(rnd_q & TAPS);
  assign span       = rnd_q[SPAN_BITS-1:0];
  assign delay_calc = CNT_W'(MIN_CNT) + CNT_W'(span);

  // LFSR next state: reseed beats stepping; a zero seed would lock up, so it becomes 1.
  always_comb begin
    rnd_d = rnd_q;
    if (seed_load) begin
      rnd_d = (seed == '0) ? WIDTH'(1) : seed;
    end else if (en) begin
      rnd_d = {rnd_q[WIDTH-2:0], fb};
    end
  end

  // Delay FSM: capture on start, count down on tick, cancel always wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_val_d = delay_val_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          delay_val_d = delay_calc;
          cnt_d       = delay_calc;
          if (delay_calc == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any delay in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= WIDTH'(RESET_SEED);
      delay_val_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      delay_val_q <= delay_val_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  assign rnd       = rnd_q;
  assign delay_val = delay_val_q;
  assign busy      = (state_q == COUNT);
  assign done      = done_q;

endmodule
